// File: rtl/seg_scan_if.sv
// seg_scan_if: BCD value in, multiplexed 7-segment drive out.
// The scanner takes the slave side; whatever feeds bcd_code takes master.
interface seg_scan_if #(
    parameter int BCD_CNT = 3
);
    logic [BCD_CNT*4-1:0] bcd_code;
    logic [BCD_CNT-1:0]   dig_sel;
    logic [7:0]           seg;
    logic                 frame_start;

    modport master (
        output bcd_code,
        input  dig_sel,
        input  seg,
        input  frame_start
    );

    modport slave (
        input  bcd_code,
        output dig_sel,
        output seg,
        output frame_start
    );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed active-low 7-segment scanner with frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan #(
    parameter int BCD_CNT   = 3,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (BCD_CNT > 1) ? $clog2(BCD_CNT) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK   = DW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(BCD_CNT - 1);

    logic [DW-1:0]        div_q, div_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [BCD_CNT*4-1:0] snap_q, snap_d;
    logic [BCD_CNT-1:0]   dig_q, dig_d;
    logic [7:0]           seg_q, seg_d;
    logic                 fs_q, fs_d;

    logic                 div_wrap;
    logic                 load;
    logic [3:0]           nib;
    logic                 lz;

    function automatic logic [7:0] dec7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    always_comb begin
        div_wrap = (div_q == DIV_MAX);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        // Snapshot only at the top of a frame so a frame never mixes values.
        load   = (div_q == '0) && (idx_q == '0);
        snap_d = load ? bus.bcd_code : snap_q;
        fs_d   = load;
    end

`ifdef SEG_SCAN_LZB_EN
    logic [BCD_CNT-1:0] lead_zero;
    logic               run_zero;

    // lead_zero[i]: nibbles i..top of the snapshot are all zero.
    always_comb begin
        run_zero  = 1'b1;
        lead_zero = '0;
        for (int i = BCD_CNT - 1; i >= 0; i--) begin
            run_zero     = run_zero && (snap_q[i*4 +: 4] == 4'd0);
            lead_zero[i] = run_zero;
        end
    end
`endif

    always_comb begin
        nib = 4'd0;
        lz  = 1'b0;
        for (int i = 0; i < BCD_CNT; i++) begin
            if (IW'(i) == idx_q) begin
                nib = snap_q[i*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
                lz  = lead_zero[i] && (i != 0);
`else
                lz  = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        dig_d = '1;
        seg_d = 8'hFF;
        if (div_q >= BLANK) begin
            for (int i = 0; i < BCD_CNT; i++) begin
                dig_d[i] = (IW'(i) != idx_q);
            end
            seg_d = lz ? 8'hFF : dec7(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            dig_q  <= '1;
            seg_q  <= 8'hFF;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            dig_q  <= dig_d;
            seg_q  <= seg_d;
            fs_q   <= fs_d;
        end
    end

    assign bus.dig_sel     = dig_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed checks of seg_scan with BCD_CNT=3, SCAN_DIV=8, BLANK_CYC=2.
// Expected segment codes are hand-derived; LZB variants follow SEG_SCAN_LZB_EN.
module tb_seg_scan;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seg_scan_if #(.BCD_CNT(3)) bus ();

    seg_scan #(
        .BCD_CNT   (3),
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] ed,
                           input logic [7:0] es, input logic ef);
        chk({tag, "_dig"}, {5'b0, bus.dig_sel}, {5'b0, ed});
        chk({tag, "_seg"}, bus.seg, es);
        chk({tag, "_fs"}, {7'b0, bus.frame_start}, {7'b0, ef});
    endtask

    // Entered just after a load edge; walks 24 cycles up to the next load.
    task automatic run_frame(input string nm, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input int chg_k, input logic [11:0] chg_v);
        logic [7:0] es;
        logic [2:0] ed;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            es = 8'hFF;
            ed = 3'b111;
            if ((k % 8) >= 2) begin
                case (k / 8)
                    0:       begin es = e0; ed = 3'b110; end
                    1:       begin es = e1; ed = 3'b101; end
                    default: begin es = e2; ed = 3'b011; end
                endcase
            end
            chk_out($sformatf("%s_k%0d", nm, k), ed, es, k == 24);
            if (k == chg_k) bus.bcd_code = chg_v;
        end
    endtask

    localparam logic [7:0] Z_HI =
`ifdef SEG_SCAN_LZB_EN
        8'hFF;
`else
        8'hC0;
`endif

    initial begin
        rst = 1'b1;
        bus.bcd_code = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_out("reset", 3'b111, 8'hFF, 1'b0);

        rst = 1'b0;
        @(negedge clk);
        chk_out("first_load", 3'b111, 8'hFF, 1'b1);
        bus.bcd_code = 12'h255;
        run_frame("f000", 8'hC0, Z_HI, Z_HI, -1, 12'h0);

        bus.bcd_code = 12'h123;
        run_frame("f255", 8'h92, 8'h92, 8'hA4, -1, 12'h0);

        run_frame("f123", 8'hB0, 8'hA4, 8'hF9, 12, 12'h456);

        bus.bcd_code = 12'h0A7;
        run_frame("f456", 8'h82, 8'h92, 8'h99, -1, 12'h0);

        bus.bcd_code = 12'h007;
        run_frame("f0A7", 8'hF8, 8'hBF, Z_HI, -1, 12'h0);

        bus.bcd_code = 12'h000;
        run_frame("f007", 8'hF8, Z_HI, Z_HI, -1, 12'h0);

        bus.bcd_code = 12'h789;
        run_frame("f000b", 8'hC0, Z_HI, Z_HI, -1, 12'h0);

        repeat (20) @(negedge clk);
        chk_out("pre_rst", 3'b011, 8'hF8, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk_out("mid_rst", 3'b111, 8'hFF, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_out("rst_load", 3'b111, 8'hFF, 1'b1);
        run_frame("f789", 8'h90, 8'h80, 8'hF8, -1, 12'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter BCD_CNT, default 3: number of BCD digits and display positions (1..8).
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per digit slot (>= 4).
REQ-003 Parameter BLANK_CYC, default 2: all-off cycles at the start of each digit slot (1 <= BLANK_CYC < SCAN_DIV).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bcd_code  input  BCD_CNT*4  packed BCD value from the bin2bcd stage; nibble i = digit i, nibble 0 least significant.
REQ-007 dig_sel  output  BCD_CNT  digit enables, active-low, registered; bit i drives display position i.
REQ-008 seg  output  8  segments, active-low, registered; order {dp,g,f,e,d,c,b,a}.
REQ-009 frame_start  output  1  registered one-cycle pulse on the cycle the input snapshot is taken.

Function
REQ-010 A divider counter div SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit index idx SHALL advance by 1, wrapping from BCD_CNT-1 to 0.
REQ-011 On every cycle with div==0 and idx==0, the snapshot register SHALL load bcd_code; bcd_code SHALL be ignored on all other cycles (no mid-frame tearing).
REQ-012 frame_start SHALL be 1 exactly one cycle after each snapshot load cycle, else 0.
REQ-013 Output registers SHALL load every cycle from the current div, idx and snapshot register value (pre-load value on the load cycle), giving one cycle of latency.
REQ-014 While div < BLANK_CYC, the next dig_sel SHALL be all ones and the next seg 8'hFF.
REQ-015 Otherwise, the next dig_sel SHALL be all ones except bit idx = 0, and the next seg SHALL be the decode of snapshot nibble idx.
REQ-016 Decode, active-low seg: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
REQ-017 Nibble values 10..15 SHALL decode to a dash, seg = 8'hBF.
REQ-018 seg[7] (dp) SHALL always be 1 (off).
REQ-019 At most one dig_sel bit SHALL be 0 on any cycle.
REQ-020 BCD_CNT == 1 SHALL be legal; idx then stays 0 and a snapshot is taken every SCAN_DIV cycles.

Reset
REQ-021 While rst=1 at a clk edge: div=0, idx=0, snapshot=0, dig_sel=all ones, seg=8'hFF, frame_start=0.
REQ-022 rst asserted mid-slot SHALL abort the frame with no partial output; the first cycle after rst falls SHALL be a snapshot load cycle.

Configuration
REQ-023 Macro SEG_SCAN_LZB_EN defined: digit i (i >= 1) SHALL be blanked (seg=8'hFF, dig_sel bit still driven low) when snapshot nibbles i..BCD_CNT-1 are all 0; digit 0 is never blanked.
REQ-024 Macro SEG_SCAN_LZB_EN undefined: every digit SHALL be decoded per REQ-016/REQ-017, leading zeros shown.

Verification (BCD_CNT=3, SCAN_DIV=8, BLANK_CYC=2)
REQ-025 Reset for 3 cycles, then release with bcd_code=12'h000 -> frame_start=1 on cycle 2 after release; dig_sel=3'b111 and seg=FF for 2 cycles per slot; slot 0 then shows dig_sel=3'b110, seg=C0.
REQ-026 bcd_code=12'h255, run one frame -> slot 0 seg=92, slot 1 seg=92, slot 2 seg=A4; dig_sel cycles 110 -> 101 -> 011, 8 cycles per slot.
REQ-027 bcd_code changes from 12'h123 to 12'h456 during slot 1 -> slots 1 and 2 still show 2 and 1; the next frame shows 6, 5, 4.
REQ-028 bcd_code=12'h0A7 -> slot 1 seg=BF (dash), slot 0 seg=F8, slot 2 seg=C0 (no LZB) or FF (LZB).
REQ-029 With SEG_SCAN_LZB_EN, bcd_code=12'h007 -> slot 0 seg=F8, slots 1 and 2 seg=FF; bcd_code=12'h000 -> slot 0 seg=C0.
REQ-030 rst pulsed for 1 cycle during slot 2 -> outputs all-off next cycle; the following cycle is a snapshot load and the bench sees dig_sel and seg restart from slot 0.
